// File: rtl/fifo_port_ctrl.sv
// Port controller for one vendor FIFO: two-way round-robin writer, latency-tracked
// reader, and a small circular output buffer presented as a valid/ready stream.
module fifo_port_ctrl #(
    parameter int WIDTH      = 8,
    parameter int RD_LATENCY = 1,
    parameter int OBUF_DEPTH = 4
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             A_VALID,
    input  logic [WIDTH-1:0] A_DATA,
    output logic             A_READY,
    input  logic             B_VALID,
    input  logic [WIDTH-1:0] B_DATA,
    output logic             B_READY,
    output logic             FIFO_WREN,
    output logic [WIDTH-1:0] FIFO_DATA,
    input  logic             FIFO_FULL,
    output logic             FIFO_RDEN,
    input  logic [WIDTH-1:0] FIFO_Q,
    input  logic             FIFO_EMPTY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_READY,
    output logic             LAST_GRANT
);
    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(OBUF_DEPTH);

    logic                  last_grant_q, last_grant_d;
    logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [WIDTH-1:0]      mem_q [OBUF_DEPTH];

    logic [CW:0] inflight;
    logic [CW:0] credit_used;
    logic        any_valid, grant_b, wren, rden, push, pop;

    // Handshake: a word moves on any interface in a cycle where its valid and
    // ready are both high; valid/data are held by the source until then.
    always_comb begin
        any_valid   = A_VALID | B_VALID;
        grant_b     = B_VALID & (~A_VALID | ~last_grant_q);
        wren        = ~RESET & EN & ~FIFO_FULL & any_valid;
        last_grant_d = wren ? grant_b : last_grant_q;

        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + {{CW{1'b0}}, rd_pipe_q[i]};
        end
        // Credits come from registered counts only, so a pop frees space next cycle.
        credit_used = inflight + {1'b0, count_q};
        rden        = ~RESET & EN & ~FIFO_EMPTY & (credit_used < DEPTH_C);

        rd_pipe_d    = '0;
        rd_pipe_d[0] = rden;
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end

        push     = rd_pipe_q[RD_LATENCY-1];
        pop      = (count_q != '0) & OUT_READY;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            last_grant_q <= 1'b1;
            rd_pipe_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pipe_q    <= rd_pipe_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`ifndef SYNTHESIS
            if (push) begin
                assert (count_q < DEPTH_C[CW-1:0])
                else $error("fifo_port_ctrl: push into full output buffer");
            end
`endif
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET && push) begin
            mem_q[wr_ptr_q] <= FIFO_Q;
        end
    end

    assign A_READY    = wren & ~grant_b;
    assign B_READY    = wren & grant_b;
    assign FIFO_WREN  = wren;
    assign FIFO_DATA  = grant_b ? B_DATA : A_DATA;
    assign FIFO_RDEN  = rden;
    assign OUT_VALID  = (count_q != '0);
    // Idle output shows zero so a discarded or consumed word never lingers.
    assign OUT_DATA   = OUT_VALID ? mem_q[rd_ptr_q] : '0;
    assign LAST_GRANT = last_grant_q;
endmodule

// File: tb/tb_fifo_port_ctrl.sv
// Directed bench for fifo_port_ctrl: table-driven write arbitration vectors plus
// hand-written read, backpressure, reset and pause sequences against a FIFO model.
module tb_fifo_port_ctrl;
  logic       clk = 1'b0;
  logic       RESET, EN, A_VALID, B_VALID, FIFO_FULL, OUT_READY;
  logic [7:0] A_DATA, B_DATA;
  logic       A_READY, B_READY, FIFO_WREN, FIFO_RDEN, OUT_VALID, LAST_GRANT;
  logic [7:0] FIFO_DATA, OUT_DATA;
  logic [7:0] fifo_q_r = 8'h00;
  logic       fifo_empty = 1'b1;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo_m[$];
  logic       rden_s = 1'b0;
  logic       wren_s = 1'b0;
  logic [7:0] data_s = 8'h00;
  logic       model_wr_en = 1'b0;

  always #5 clk = ~clk;

  fifo_port_ctrl #(.WIDTH(8), .RD_LATENCY(1), .OBUF_DEPTH(4)) dut (
    .CLOCK(clk), .RESET(RESET), .EN(EN),
    .A_VALID(A_VALID), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_DATA(B_DATA), .B_READY(B_READY),
    .FIFO_WREN(FIFO_WREN), .FIFO_DATA(FIFO_DATA), .FIFO_FULL(FIFO_FULL),
    .FIFO_RDEN(FIFO_RDEN), .FIFO_Q(fifo_q_r), .FIFO_EMPTY(fifo_empty),
    .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
    .LAST_GRANT(LAST_GRANT)
  );

  typedef struct packed {
    logic       rst, en, av, bv, full;
    logic [7:0] ad, bd;
    logic       e_wren, e_ar, e_br;
    logic [7:0] e_data;
    logic       e_last;
  } wvec_t;

  wvec_t wv[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle: FIFO model reacts 1ns after the edge, then wait for the negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (rden_s && fifo_m.size() > 0) fifo_q_r = fifo_m.pop_front();
    if (wren_s && model_wr_en) fifo_m.push_back(data_s);
    fifo_empty = (fifo_m.size() == 0);
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    rden_s = FIFO_RDEN;
    wren_s = FIFO_WREN;
    data_s = FIFO_DATA;
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_m.push_back(base + 8'(i));
    fifo_empty = (fifo_m.size() == 0);
  endtask

  int         pulses;
  logic [7:0] got[$];
  logic       r1_rden[7]  = '{1, 1, 1, 0, 0, 0, 0};
  logic       r1_valid[7] = '{0, 0, 1, 1, 1, 0, 0};
  logic [7:0] r1_data[7]  = '{8'h00, 8'h00, 8'h65, 8'h66, 8'h67, 8'h00, 8'h00};

  initial begin
    //            rst en av bv fu  ad     bd     wr ar br data   last
    wv[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h65, 1'b1};
    wv[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b1, 1'b0, 8'h65, 1'b1};
    wv[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    wv[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b1, 1'b0, 8'h65, 1'b1};
    wv[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    wv[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h65, 1'b1};
    wv[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h65, 1'b1};
    wv[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h65, 1'b1};
    wv[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b1, 1'b0, 8'h65, 1'b1};
    wv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    wv[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66, 1'b1};
    wv[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h65, 8'h66, 1'b1, 1'b1, 1'b0, 8'h65, 1'b1};
    wv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h65, 1'b0};
    wv[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h66, 1'b0};
    wv[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0};
    wv[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b0, 1'b0, 1'b0, 8'h65, 1'b1};
    wv[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h65, 8'h66, 1'b1, 1'b1, 1'b0, 8'h65, 1'b1};

    // Clock/reset preamble
    RESET = 1'b1; EN = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0; FIFO_FULL = 1'b0;
    OUT_READY = 1'b1; A_DATA = 8'h65; B_DATA = 8'h66;
    next_cycle();
    next_cycle();
    settle();
    chk("rst_out_valid", OUT_VALID, 1'b0);
    chk("rst_out_data", OUT_DATA, 8'h00);
    chk("rst_last_grant", LAST_GRANT, 1'b1);
    chk("rst_rden", FIFO_RDEN, 1'b0);

    // Write arbitration vectors (accepted words are not stored in the model)
    for (int v = 0; v < 17; v++) begin
      next_cycle();
      RESET = wv[v].rst; EN = wv[v].en; A_VALID = wv[v].av; B_VALID = wv[v].bv;
      FIFO_FULL = wv[v].full; A_DATA = wv[v].ad; B_DATA = wv[v].bd;
      settle();
      chk($sformatf("wr%0d_wren", v), FIFO_WREN, wv[v].e_wren);
      chk($sformatf("wr%0d_a_ready", v), A_READY, wv[v].e_ar);
      chk($sformatf("wr%0d_b_ready", v), B_READY, wv[v].e_br);
      chk($sformatf("wr%0d_data", v), FIFO_DATA, wv[v].e_data);
      chk($sformatf("wr%0d_last", v), LAST_GRANT, wv[v].e_last);
    end

    // Three preloaded words stream out back-to-back
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      RESET = 1'b0; EN = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0; FIFO_FULL = 1'b0; OUT_READY = 1'b1;
      if (c == 0) preload(8'h65, 3);
      settle();
      chk($sformatf("rd1_c%0d_rden", c), FIFO_RDEN, r1_rden[c]);
      chk($sformatf("rd1_c%0d_valid", c), OUT_VALID, r1_valid[c]);
      if (r1_valid[c]) chk($sformatf("rd1_c%0d_data", c), OUT_DATA, r1_data[c]);
    end

    // Backpressure: ten words, consumer stalled, credits cap reads at four
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      OUT_READY = 1'b0;
      if (c == 0) preload(8'h10, 10);
      settle();
      if (FIFO_RDEN) pulses++;
    end
    chk("bp_rden_pulses", pulses, 4);
    chk("bp_out_valid", OUT_VALID, 1'b1);
    chk("bp_head", OUT_DATA, 8'h10);
    got.delete();
    for (int c = 0; c < 40 && got.size() < 10; c++) begin
      next_cycle();
      OUT_READY = 1'b1;
      settle();
      if (OUT_VALID) got.push_back(OUT_DATA);
    end
    chk("bp_word_count", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("bp_word%0d", i), got[i], 8'h10 + 8'(i));

    // Reset with one read in flight and two words buffered
    next_cycle();
    settle();
    chk("pre_reset_idle", OUT_VALID, 1'b0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      OUT_READY = 1'b0;
      if (c == 0) preload(8'h30, 5);
      if (c == 3) begin RESET = 1'b1; A_VALID = 1'b1; end
      settle();
      if (c == 3) begin
        chk("mid_rst_buffered", OUT_VALID, 1'b1);
        chk("mid_rst_rden", FIFO_RDEN, 1'b0);
        chk("mid_rst_wren", FIFO_WREN, 1'b0);
        chk("mid_rst_a_ready", A_READY, 1'b0);
      end
    end
    next_cycle();
    RESET = 1'b0; EN = 1'b0; A_VALID = 1'b0; OUT_READY = 1'b1;
    settle();
    chk("post_rst_valid", OUT_VALID, 1'b0);
    chk("post_rst_data", OUT_DATA, 8'h00);
    chk("post_rst_last", LAST_GRANT, 1'b1);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      settle();
      chk($sformatf("post_rst_nostale%0d", c), OUT_VALID, 1'b0);
    end

    // Pause with one read in flight: the word lands, nothing new issues
    next_cycle();
    EN = 1'b1;
    settle();
    chk("en_issue_rden", FIFO_RDEN, 1'b1);
    next_cycle();
    EN = 1'b0; A_VALID = 1'b1; B_VALID = 1'b1;
    settle();
    chk("en0_rden", FIFO_RDEN, 1'b0);
    chk("en0_wren", FIFO_WREN, 1'b0);
    chk("en0_a_ready", A_READY, 1'b0);
    chk("en0_b_ready", B_READY, 1'b0);
    next_cycle();
    settle();
    chk("en0_inflight_valid", OUT_VALID, 1'b1);
    chk("en0_inflight_data", OUT_DATA, 8'h33);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      settle();
      chk($sformatf("en0_hold%0d_rden", c), FIFO_RDEN, 1'b0);
      chk($sformatf("en0_hold%0d_wren", c), FIFO_WREN, 1'b0);
      chk($sformatf("en0_hold%0d_valid", c), OUT_VALID, 1'b0);
    end
    next_cycle();
    EN = 1'b1; A_VALID = 1'b0; B_VALID = 1'b0;
    settle();
    chk("en1_resume_rden", FIFO_RDEN, 1'b1);
    next_cycle();
    settle();
    chk("en1_empty_rden", FIFO_RDEN, 1'b0);
    next_cycle();
    settle();
    chk("en1_last_valid", OUT_VALID, 1'b1);
    chk("en1_last_data", OUT_DATA, 8'h34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
